// File: rtl/rstack_ctrl.sv
// Return-stack controller: owns the stack pointer and a cached top-of-stack
// register, and drives the ports of an external memory with asynchronous read
// and synchronous write. Overflow and underflow latch a sticky fault that
// freezes the stack until it is cleared.
module rstack_ctrl #(
    parameter int unsigned WIDTH      = 13,
    parameter int unsigned DEPTH      = 8192,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full,
    output logic [WIDTH:0]        level,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [WIDTH-1:0]      mem_dout_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  we,
    output logic [WIDTH-1:0]      mem_din_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);

    typedef enum logic [0:0] {
        StRun,
        StFault
    } state_e;

    localparam logic [WIDTH:0]   SpMax   = (WIDTH + 1)'(DEPTH);
    localparam logic [WIDTH:0]   SpOne   = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] AddrOne = WIDTH'(1);

    localparam logic [1:0] CodeNone      = 2'b00;
    localparam logic [1:0] CodeOverflow  = 2'b01;
    localparam logic [1:0] CodeUnderflow = 2'b10;

    state_e                  state_q, state_d;
    logic [WIDTH:0]          sp_q, sp_d;
    logic                    tos_valid_q, tos_valid_d;
    logic [DATA_WIDTH-1:0]   tos_q, tos_d;
    logic [1:0]              code_q, code_d;

    logic is_full;
    logic is_empty;

    assign is_empty = !tos_valid_q;
    assign is_full  = tos_valid_q && (sp_q == SpMax);

    assign empty = is_empty;
    assign full  = is_full;
    assign level = sp_q;
    assign top   = tos_q;

    // The slot below the pointer is the most recent spill; wraps harmlessly at sp=0.
    assign mem_dout_addr = sp_q[WIDTH-1:0] - AddrOne;
    assign mem_din_addr  = sp_q[WIDTH-1:0];
    assign mem_din       = tos_q;

    // State register: pointer, cached top, FSM state and fault code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            sp_q        <= '0;
            tos_valid_q <= 1'b0;
            tos_q       <= '0;
            code_q      <= CodeNone;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            tos_valid_q <= tos_valid_d;
            tos_q       <= tos_d;
            code_q      <= code_d;
        end
    end

    // Next-state: decode push/pop in RUN, wait for clear in FAULT.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        tos_valid_d = tos_valid_q;
        tos_d       = tos_q;
        code_d      = code_q;
        unique case (state_q)
            StRun: begin
                unique case ({push, pop})
                    2'b10: begin
                        if (is_full) begin
                            state_d = StFault;
                            code_d  = CodeOverflow;
                        end else begin
                            // Spill the old top only if there is one.
                            if (tos_valid_q) begin
                                sp_d = sp_q + SpOne;
                            end
                            tos_d       = push_data;
                            tos_valid_d = 1'b1;
                        end
                    end
                    2'b01: begin
                        if (is_empty) begin
                            state_d = StFault;
                            code_d  = CodeUnderflow;
                        end else if (sp_q != '0) begin
                            tos_d = mem_dout;
                            sp_d  = sp_q - SpOne;
                        end else begin
                            // Stale tos value is kept; only validity drops.
                            tos_valid_d = 1'b0;
                        end
                    end
                    2'b11: begin
                        // Tail call: replace the top in place, legal even when full.
                        if (is_empty) begin
                            state_d = StFault;
                            code_d  = CodeUnderflow;
                        end else begin
                            tos_d = push_data;
                        end
                    end
                    default: ;
                endcase
            end
            StFault: begin
                if (clear) begin
                    state_d = StRun;
                    code_d  = CodeNone;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Outputs: memory write strobe and fault status.
    always_comb begin
        we         = 1'b0;
        fault      = 1'b0;
        fault_code = code_q;
        if (state_q == StRun) begin
            we = push && !pop && !is_full && tos_valid_q;
        end else begin
            fault = 1'b1;
        end
    end

endmodule

// File: tb/tb_rstack_ctrl.sv
// Directed bench for rstack_ctrl with a behavioural rstack memory model
// (asynchronous read, synchronous write).
`timescale 1ns/1ps
module tb_rstack_ctrl;

    localparam int unsigned WIDTH      = 13;
    localparam int unsigned DEPTH      = 8192;
    localparam int unsigned DATA_WIDTH = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  clear;
    logic [DATA_WIDTH-1:0] top;
    logic                  empty;
    logic                  full;
    logic [WIDTH:0]        level;
    logic                  fault;
    logic [1:0]            fault_code;
    logic [WIDTH-1:0]      mem_dout_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  we;
    logic [WIDTH-1:0]      mem_din_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    int checks;
    int failures;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    rstack_ctrl #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .pop           (pop),
        .push_data     (push_data),
        .clear         (clear),
        .top           (top),
        .empty         (empty),
        .full          (full),
        .level         (level),
        .fault         (fault),
        .fault_code    (fault_code),
        .mem_dout_addr (mem_dout_addr),
        .mem_dout      (mem_dout),
        .we            (we),
        .mem_din_addr  (mem_din_addr),
        .mem_din       (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rstack model
    always @(posedge clk) begin
        if (we) mem[mem_din_addr] <= mem_din;
    end
    assign mem_dout = mem[mem_dout_addr];

    task automatic tick();
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
        checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL reset_code got=%b exp=00", fault_code); end
        checks++; if (top !== 16'h0000) begin failures++; $display("FAIL reset_top got=%h exp=0000", top); end
        checks++; if (level !== 14'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
    endtask

    task automatic test_push_pop();
        logic [15:0] vals [3];
        logic [15:0] exp_top [3];
        logic [13:0] exp_lvl [3];
        vals = '{16'h1111, 16'h2222, 16'h3333};
        exp_top = '{16'h2222, 16'h1111, 16'h1111};
        exp_lvl = '{14'd1, 14'd0, 14'd0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = vals[i];
            #1;
            checks++;
            if (we !== (i > 0)) begin failures++; $display("FAIL push%0d_we got=%b exp=%b", i, we, (i > 0)); end
            if (i > 0) begin
                checks++;
                if (mem_din_addr !== 13'(i - 1) || mem_din !== vals[i-1]) begin
                    failures++;
                    $display("FAIL push%0d_wport got=%h/%h exp=%h/%h", i, mem_din_addr, mem_din,
                             13'(i - 1), vals[i-1]);
                end
            end
            tick();
            checks++;
            if (top !== vals[i] || level !== 14'(i)) begin
                failures++;
                $display("FAIL push%0d_state got=%h/%0d exp=%h/%0d", i, top, level, vals[i], i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            #1;
            checks++; if (we !== 1'b0) begin failures++; $display("FAIL pop%0d_we got=%b exp=0", i, we); end
            tick();
            checks++;
            if (level !== exp_lvl[i] || top !== exp_top[i] || empty !== (i == 2)) begin
                failures++;
                $display("FAIL pop%0d_state got=%h/%0d/%b exp=%h/%0d/%b", i, top, level, empty,
                         exp_top[i], exp_lvl[i], (i == 2));
            end
        end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL pushpop_fault got=%b exp=0", fault); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            push = 1'b1; push_data = 16'(i);
            tick();
        end
        checks++;
        if (full !== 1'b1 || level !== 14'(DEPTH) || top !== 16'(DEPTH)) begin
            failures++;
            $display("FAIL fill_full got=%b/%0d/%h exp=1/%0d/%h", full, level, top, DEPTH, 16'(DEPTH));
        end
        push = 1'b1; push_data = 16'hDEAD;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL ovf_we got=%b exp=0", we); end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || top !== 16'(DEPTH) || level !== 14'(DEPTH)) begin
            failures++;
            $display("FAIL ovf_state got=%b/%b/%h/%0d exp=1/01/%h/%0d", fault, fault_code, top, level,
                     16'(DEPTH), DEPTH);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
            failures++; $display("FAIL ovf_clear got=%b/%b exp=0/00", fault, fault_code);
        end
        pop = 1'b1;
        tick();
        checks++;
        if (top !== 16'(DEPTH - 1) || level !== 14'(DEPTH - 1)) begin
            failures++;
            $display("FAIL fill_pop got=%h/%0d exp=%h/%0d", top, level, 16'(DEPTH - 1), DEPTH - 1);
        end
        push = 1'b1; push_data = 16'h7777;
        tick();
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL refill_full got=%b exp=1", full); end
        push = 1'b1; pop = 1'b1; push_data = 16'h5A5A;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL full_tail_we got=%b exp=0", we); end
        tick();
        checks++;
        if (top !== 16'h5A5A || fault !== 1'b0 || level !== 14'(DEPTH) || full !== 1'b1) begin
            failures++;
            $display("FAIL full_tail got=%h/%b/%0d/%b exp=5a5a/0/%0d/1", top, fault, level, full, DEPTH);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        pop = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || empty !== 1'b1) begin
            failures++; $display("FAIL udf_state got=%b/%b/%b exp=1/10/1", fault, fault_code, empty);
        end
        push = 1'b1; push_data = 16'h1234;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL fault_push_we got=%b exp=0", we); end
        tick();
        checks++;
        if (empty !== 1'b1 || level !== 14'd0 || fault !== 1'b1 || fault_code !== 2'b10) begin
            failures++;
            $display("FAIL fault_push got=%b/%0d/%b/%b exp=1/0/1/10", empty, level, fault, fault_code);
        end
        // strobe together with clear is ignored
        clear = 1'b1; push = 1'b1; push_data = 16'h4321;
        tick();
        checks++;
        if (fault !== 1'b0 || empty !== 1'b1 || fault_code !== 2'b00) begin
            failures++; $display("FAIL clear_push got=%b/%b/%b exp=0/1/00", fault, empty, fault_code);
        end
        clear = 1'b1;
        tick();
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL clear_in_run got=%b exp=0", fault); end
    endtask

    task automatic test_tail_call();
        do_reset();
        push = 1'b1; push_data = 16'hAAAA;
        tick();
        push = 1'b1; pop = 1'b1; push_data = 16'hBBBB;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL tail_we got=%b exp=0", we); end
        tick();
        checks++;
        if (top !== 16'hBBBB || level !== 14'd0 || empty !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL tail_state got=%h/%0d/%b/%b exp=bbbb/0/0/0", top, level, empty, fault);
        end
        pop = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL tail_pop got=%b exp=1", empty); end
        push = 1'b1; pop = 1'b1; push_data = 16'hCCCC;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || empty !== 1'b1) begin
            failures++; $display("FAIL tail_udf got=%b/%b/%b exp=1/10/1", fault, fault_code, empty);
        end
        clear = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; push_data = 16'h0100 + 16'(i);
            tick();
        end
        checks++; if (level !== 14'd5) begin failures++; $display("FAIL pre_rst_level got=%0d exp=5", level); end
        push = 1'b1; push_data = 16'h9999;
        #1;
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL pre_rst_we got=%b exp=1", we); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || level !== 14'd0 || empty !== 1'b1 || top !== 16'h0000 || full !== 1'b0
            || fault !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got=%b/%0d/%b/%h/%b/%b exp=0/0/1/0000/0/0", we, level, empty, top,
                     full, fault);
        end
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pop = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10) begin
            failures++; $display("FAIL rst_then_pop got=%b/%b exp=1/10", fault, fault_code);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
        test_reset();
        test_push_pop();
        test_underflow();
        test_tail_call();
        test_async_reset();
        test_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
